ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 29 ++
 rtl/ram_arb_rr.sv | 50 +++++
 rtl/ram_port_arbiter.sv | 106 ++++++++++
 tb/tb_ram_port_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the multi-host single-port RAM arbiter.
// Request/response payloads plus the fixed RAM read latency.
package ram_arb_pkg;

    localparam int unsigned DataW      = 32;
    localparam int unsigned AddrW      = 32;
    localparam int unsigned BeW        = 4;
    localparam int unsigned RamLatency = 1;

    typedef struct packed {
        logic             we;
        logic [BeW-1:0]   be;
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] wdata;
    } ram_req_t;

    typedef struct packed {
        logic             rvalid;
        logic             err;
        logic [DataW-1:0] rdata;
    } ram_rsp_t;

    // Byte address is valid when it falls inside depth 32-bit words.
    function automatic logic addr_in_range(input logic [AddrW-1:0] addr,
                                           input int unsigned depth);
        return addr < AddrW'(depth * 4);
    endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Round-robin grant selection: combinational one-hot grant, priority pointer
// holds the host searched first and moves only when a grant is issued.
module ram_arb_rr #(
    parameter int unsigned NumHosts = 3,
    localparam int unsigned IdW     = $clog2(NumHosts)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumHosts-1:0] req_i,
    output logic [NumHosts-1:0] gnt_o,
    output logic [IdW-1:0]      gnt_id_o,
    output logic                gnt_valid_o
);

    logic [IdW-1:0] ptr_q, ptr_d;

    always_comb begin
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        ptr_d       = ptr_q;
        for (int unsigned i = 0; i < NumHosts; i++) begin
            logic [IdW:0]   cand;
            logic [IdW-1:0] idx;
            // One extra bit so ptr + i cannot overflow before the modulo wrap.
            cand = (IdW+1)'(ptr_q) + (IdW+1)'(i);
            if (cand >= (IdW+1)'(NumHosts)) begin
                cand = cand - (IdW+1)'(NumHosts);
            end
            idx = IdW'(cand);
            if (!gnt_valid_o && !rst_i && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = idx;
                gnt_o[idx]  = 1'b1;
            end
        end
        if (gnt_valid_o) begin
            ptr_d = (gnt_id_o == IdW'(NumHosts - 1)) ? '0 : gnt_id_o + IdW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 1-cycle-latency RAM port among NumHosts requesters; out-of-range
// accesses are granted but answered locally with an error response.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NumHosts = 3,
    parameter int unsigned Depth    = 128
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumHosts-1:0]       host_req_i,
    input  logic [NumHosts-1:0]       host_we_i,
    input  logic [NumHosts*BeW-1:0]   host_be_i,
    input  logic [NumHosts*AddrW-1:0] host_addr_i,
    input  logic [NumHosts*DataW-1:0] host_wdata_i,
    output logic [NumHosts-1:0]       host_gnt_o,
    output logic [NumHosts-1:0]       host_rvalid_o,
    output logic [NumHosts-1:0]       host_err_o,
    output logic [DataW-1:0]          host_rdata_o,
    output logic                      ram_req_o,
    output logic                      ram_we_o,
    output logic [BeW-1:0]            ram_be_o,
    output logic [AddrW-1:0]          ram_addr_o,
    output logic [DataW-1:0]          ram_wdata_o,
    input  logic                      ram_rvalid_i,
    input  logic [DataW-1:0]          ram_rdata_i
);

    localparam int unsigned IdW = $clog2(NumHosts);

    logic [NumHosts-1:0] gnt_c;
    logic [IdW-1:0]      gnt_id_c;
    logic                gnt_valid_c;
    ram_req_t            sel_c;
    logic                oor_c;
    ram_rsp_t            rsp_c;

    logic           pend_q, pend_d;
    logic [IdW-1:0] id_q, id_d;
    logic           err_q, err_d;
    logic           we_q, we_d;

    ram_arb_rr #(.NumHosts(NumHosts)) u_rr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (host_req_i),
        .gnt_o      (gnt_c),
        .gnt_id_o   (gnt_id_c),
        .gnt_valid_o(gnt_valid_c)
    );

    // Forward the granted host's request to the RAM port.
    always_comb begin
        sel_c = '0;
        for (int unsigned h = 0; h < NumHosts; h++) begin
            if (gnt_c[h]) begin
                sel_c.we    = host_we_i[h];
                sel_c.be    = host_be_i[h*BeW +: BeW];
                sel_c.addr  = host_addr_i[h*AddrW +: AddrW];
                sel_c.wdata = host_wdata_i[h*DataW +: DataW];
            end
        end
        oor_c       = gnt_valid_c && !addr_in_range(sel_c.addr, Depth);
        host_gnt_o  = gnt_c;
        ram_req_o   = gnt_valid_c && !oor_c;
        ram_we_o    = sel_c.we;
        ram_be_o    = sel_c.be;
        ram_addr_o  = sel_c.addr;
        ram_wdata_o = sel_c.wdata;
        pend_d      = gnt_valid_c;
        id_d        = gnt_id_c;
        err_d       = oor_c;
        we_d        = sel_c.we;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            id_q   <= '0;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            id_q   <= id_d;
            err_q  <= err_d;
            we_q   <= we_d;
        end
    end

    // Response routed to the host granted RamLatency cycle(s) earlier.
    always_comb begin
        rsp_c.rvalid = pend_q;
        rsp_c.err    = pend_q && err_q;
        rsp_c.rdata  = (pend_q && !err_q && !we_q) ? ram_rdata_i : '0;
        host_rvalid_o       = '0;
        host_err_o          = '0;
        host_rvalid_o[id_q] = rsp_c.rvalid;
        host_err_o[id_q]    = rsp_c.err;
        host_rdata_o        = rsp_c.rdata;
    end

    assert property (@(posedge clk_i) disable iff (rst_i)
                     ram_rvalid_i == (pend_q && !err_q))
        else $error("ram_rvalid_i does not match in-range pending access");

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural RAM.
module tb_ram_port_arbiter;

    localparam int unsigned NumHosts = 3;
    localparam int unsigned Depth    = 128;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [NumHosts-1:0]    host_req_i;
    logic [NumHosts-1:0]    host_we_i;
    logic [NumHosts*4-1:0]  host_be_i;
    logic [NumHosts*32-1:0] host_addr_i;
    logic [NumHosts*32-1:0] host_wdata_i;
    logic [NumHosts-1:0]    host_gnt_o;
    logic [NumHosts-1:0]    host_rvalid_o;
    logic [NumHosts-1:0]    host_err_o;
    logic [31:0]            host_rdata_o;
    logic                   ram_req_o;
    logic                   ram_we_o;
    logic [3:0]             ram_be_o;
    logic [31:0]            ram_addr_o;
    logic [31:0]            ram_wdata_o;
    logic                   ram_rvalid_i;
    logic [31:0]            ram_rdata_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [Depth];

    ram_port_arbiter #(.NumHosts(NumHosts), .Depth(Depth)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_be_i    (host_be_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_gnt_o   (host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
        .host_err_o   (host_err_o),
        .host_rdata_o (host_rdata_o),
        .ram_req_o    (ram_req_o),
        .ram_we_o     (ram_we_o),
        .ram_be_o     (ram_be_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_rvalid_i (ram_rvalid_i),
        .ram_rdata_i  (ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Single-port RAM, one cycle read latency, byte-enabled writes.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ram_rvalid_i <= 1'b0;
        end else begin
            ram_rvalid_i <= ram_req_o;
            if (ram_req_o) begin
                if (ram_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_be_o[b]) mem[ram_addr_o[8:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
                end else begin
                    ram_rdata_i <= mem[ram_addr_o[8:2]];
                end
            end
        end
    end

    task automatic clear_hosts();
        host_req_i   = '0;
        host_we_i    = '0;
        host_be_i    = '0;
        host_addr_i  = '0;
        host_wdata_i = '0;
    endtask

    task automatic set_host(input int h, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        host_req_i[h]            = 1'b1;
        host_we_i[h]             = we;
        host_be_i[h*4 +: 4]      = be;
        host_addr_i[h*32 +: 32]  = addr;
        host_wdata_i[h*32 +: 32] = wdata;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_hosts();
        for (int h = 0; h < NumHosts; h++) set_host(h, 1'b0, 4'hF, 32'(h * 4), 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (host_gnt_o !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", host_gnt_o); end
        checks++; if (ram_req_o !== 1'b0) begin failures++; $display("FAIL reset_ram_req got=%b exp=0", ram_req_o); end
        checks++; if (host_rvalid_o !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", host_rvalid_o); end
        checks++; if (host_err_o !== 3'b000) begin failures++; $display("FAIL reset_err got=%b exp=000", host_err_o); end
        @(negedge clk_i);
        clear_hosts();
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        for (int h = 0; h < NumHosts; h++) set_host(h, 1'b0, 4'hF, 32'h20 + 32'(h * 4), 32'h0);
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            @(negedge clk_i); #1;
            checks++; if (host_gnt_o !== exp_g) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, host_gnt_o, exp_g); end
            @(posedge clk_i); #1;
            checks++; if (host_rvalid_o !== exp_g || host_err_o !== 3'b000) begin
                failures++; $display("FAIL rr_rvalid[%0d] got=%b err=%b exp=%b err=000", k, host_rvalid_o, host_err_o, exp_g);
            end
        end
        clear_hosts();
    endtask

    task automatic test_write_read();
        set_host(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        @(negedge clk_i); #1;
        checks++; if (host_gnt_o !== 3'b010 || ram_req_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 32'h10) begin
            failures++; $display("FAIL wr_grant got gnt=%b req=%b we=%b addr=%h exp gnt=010 req=1 we=1 addr=10", host_gnt_o, ram_req_o, ram_we_o, ram_addr_o);
        end
        @(posedge clk_i); #1;
        checks++; if (host_rvalid_o !== 3'b010 || host_err_o !== 3'b000 || host_rdata_o !== 32'h0) begin
            failures++; $display("FAIL wr_resp got rvalid=%b err=%b rdata=%h exp 010 000 0", host_rvalid_o, host_err_o, host_rdata_o);
        end
        clear_hosts();
        set_host(2, 1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk_i); #1;
        checks++; if (host_gnt_o !== 3'b100) begin failures++; $display("FAIL rd_grant got=%b exp=100", host_gnt_o); end
        @(posedge clk_i); #1;
        checks++; if (host_rvalid_o !== 3'b100 || host_err_o !== 3'b000 || host_rdata_o !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rd_resp got rvalid=%b err=%b rdata=%h exp 100 000 deadbeef", host_rvalid_o, host_err_o, host_rdata_o);
        end
        clear_hosts();
    endtask

    task automatic test_out_of_range();
        set_host(0, 1'b0, 4'hF, 32'h200, 32'h0);
        @(negedge clk_i); #1;
        checks++; if (host_gnt_o !== 3'b001 || ram_req_o !== 1'b0) begin
            failures++; $display("FAIL oor_grant got gnt=%b ram_req=%b exp gnt=001 ram_req=0", host_gnt_o, ram_req_o);
        end
        @(posedge clk_i); #1;
        checks++; if (host_rvalid_o !== 3'b001 || host_err_o !== 3'b001 || host_rdata_o !== 32'h0) begin
            failures++; $display("FAIL oor_resp got rvalid=%b err=%b rdata=%h exp 001 001 0", host_rvalid_o, host_err_o, host_rdata_o);
        end
        clear_hosts();
    endtask

    task automatic test_wrap();
        logic [2:0] req_v [5];
        logic [2:0] exp_v [5];
        req_v = '{3'b100, 3'b100, 3'b011, 3'b000, 3'b111};
        exp_v = '{3'b100, 3'b100, 3'b001, 3'b000, 3'b010};
        for (int k = 0; k < 5; k++) begin
            clear_hosts();
            for (int h = 0; h < NumHosts; h++) if (req_v[k][h]) set_host(h, 1'b0, 4'hF, 32'h40, 32'h0);
            @(negedge clk_i); #1;
            checks++; if (host_gnt_o !== exp_v[k]) begin failures++; $display("FAIL wrap_gnt[%0d] got=%b exp=%b", k, host_gnt_o, exp_v[k]); end
            @(posedge clk_i); #1;
        end
        clear_hosts();
    endtask

    task automatic test_reset_mid();
        set_host(1, 1'b0, 4'hF, 32'h8, 32'h0);
        @(negedge clk_i); #1;
        checks++; if (host_gnt_o !== 3'b010) begin failures++; $display("FAIL rstmid_gnt got=%b exp=010", host_gnt_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        for (int h = 0; h < NumHosts; h++) set_host(h, 1'b0, 4'hF, 32'h8, 32'h0);
        #1;
        checks++; if (host_rvalid_o !== 3'b000 || host_gnt_o !== 3'b000 || ram_req_o !== 1'b0) begin
            failures++; $display("FAIL rstmid_hold got rvalid=%b gnt=%b ram_req=%b exp 000 000 0", host_rvalid_o, host_gnt_o, ram_req_o);
        end
        @(negedge clk_i);
        clear_hosts();
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (host_rvalid_o !== 3'b000) begin failures++; $display("FAIL rstmid_norvalid got=%b exp=000", host_rvalid_o); end
        for (int h = 0; h < NumHosts; h++) set_host(h, 1'b0, 4'hF, 32'h8, 32'h0);
        @(negedge clk_i); #1;
        checks++; if (host_gnt_o !== 3'b001) begin failures++; $display("FAIL rstmid_first_gnt got=%b exp=001", host_gnt_o); end
        @(posedge clk_i); #1;
        checks++; if (host_rvalid_o !== 3'b001) begin failures++; $display("FAIL rstmid_first_rvalid got=%b exp=001", host_rvalid_o); end
        clear_hosts();
    endtask

    task automatic test_byte_write();
        set_host(1, 1'b1, 4'h2, 32'h0, 32'hFFFFABFF);
        @(negedge clk_i); #1;
        checks++; if (host_gnt_o !== 3'b010 || ram_be_o !== 4'h2 || ram_wdata_o !== 32'hFFFFABFF) begin
            failures++; $display("FAIL bw_grant got gnt=%b be=%h wdata=%h exp 010 2 ffffabff", host_gnt_o, ram_be_o, ram_wdata_o);
        end
        @(posedge clk_i); #1;
        clear_hosts();
        set_host(1, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk_i); #1;
        checks++; if (host_gnt_o !== 3'b010) begin failures++; $display("FAIL bw_rd_gnt got=%b exp=010", host_gnt_o); end
        @(posedge clk_i); #1;
        checks++; if (host_rvalid_o !== 3'b010 || host_rdata_o !== 32'h0000AB00) begin
            failures++; $display("FAIL bw_readback got rvalid=%b rdata=%h exp 010 0000ab00", host_rvalid_o, host_rdata_o);
        end
        clear_hosts();
    endtask

    initial begin
        for (int i = 0; i < int'(Depth); i++) mem[i] = 32'h0;
        ram_rdata_i = 32'h0;
        test_reset();
        test_round_robin();
        test_write_read();
        test_out_of_range();
        test_wrap();
        test_reset_mid();
        test_byte_write();
        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
